ycr1_pipe_mprf_wb: RTL and testbench

Write-back merge stage that sits directly upstream of the MPRF write port. It accepts results from two producers: the EXU ALU/CSR/MUL path, which has a valid/ready handshake, and the LSU load-return path, which is always accepted. It serialises both into the single registered MPRF write request and buffers ALU results in a small FIFO when the two collide. It also provides rs1/rs2 pending-write forwarding, so an operand read during the in-flight window returns the newest value.

---
 rtl/ycr1_pipe_mprf_wb.sv | 238 +++++++++++++++++++++++
 tb/tb_ycr1_pipe_mprf_wb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_pipe_mprf_wb.sv
// ycr1_pipe_mprf_wb
// Write-back merge stage in front of the MPRF write port. It merges two
// producers into one registered MPRF write request:
//   - EXU ALU/CSR/MUL results, which use a valid/ready handshake;
//   - LSU load returns, which are always taken in the cycle they arrive.
// When both arrive together, the load wins the write port and the ALU result
// waits in a small circular FIFO. A load is younger than every buffered ALU
// result, so buffered entries with the same rd are squashed when the load is
// written. Operand forwarding covers the whole window between capture and the
// MPRF write edge.
module ycr1_pipe_mprf_wb #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 2     // 2 or 4; pointers wrap as plain binary counters
) (
    input  logic              rst_n,
    input  logic              clk,

    input  logic              alu_wb_req_i,
    input  logic [AWIDTH-1:0] alu_wb_addr_i,
    input  logic [XLEN-1:0]   alu_wb_data_i,
    output logic              alu_wb_rdy_o,

    input  logic              lsu_wb_req_i,
    input  logic [AWIDTH-1:0] lsu_wb_addr_i,
    input  logic [XLEN-1:0]   lsu_wb_data_i,

    output logic              exu2mprf_w_req_o,
    output logic [AWIDTH-1:0] exu2mprf_rd_addr_o,
    output logic [XLEN-1:0]   exu2mprf_rd_data_o,

    input  logic [AWIDTH-1:0] rs1_addr_i,
    input  logic [AWIDTH-1:0] rs2_addr_i,
    output logic              rs1_fwd_vd_o,
    output logic              rs2_fwd_vd_o,
    output logic [XLEN-1:0]   rs1_fwd_data_o,
    output logic [XLEN-1:0]   rs2_fwd_data_o,

    output logic              wb_idle_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    // FIFO storage and control
    logic [AWIDTH-1:0] ent_addr_q [DEPTH];
    logic [XLEN-1:0]   ent_data_q [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q;
    logic [DEPTH-1:0]  ent_vld_d;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;

    // Output (MPRF write) register
    logic              w_req_q;
    logic              w_req_d;
    logic [AWIDTH-1:0] w_addr_q;
    logic [AWIDTH-1:0] w_addr_d;
    logic [XLEN-1:0]   w_data_q;
    logic [XLEN-1:0]   w_data_d;

    // Per-cycle decisions
    logic              fifo_empty;
    logic              lsu_sel;
    logic              alu_acc;
    logic              alu_nz;
    logic              head_sel;
    logic              byp_sel;
    logic              enq;
    logic              deq;

    // Forwarding helpers: physical slot and liveness by age (0 = oldest)
    logic [PW-1:0]     slot_idx  [DEPTH];
    logic [DEPTH-1:0]  slot_live;

    // Ready depends only on the registered count, never on this cycle's requests
    always_comb begin
        fifo_empty   = (cnt_q == '0);
        alu_wb_rdy_o = (cnt_q < CW'(DEPTH));
    end

    // Source selection: LSU (rd!=0) > FIFO head > ALU bypass when FIFO is empty
    always_comb begin
        lsu_sel  = lsu_wb_req_i & (lsu_wb_addr_i != '0);
        alu_acc  = alu_wb_req_i & alu_wb_rdy_o;
        alu_nz   = alu_acc & (alu_wb_addr_i != '0);
        head_sel = ~lsu_sel & ~fifo_empty;
        byp_sel  = ~lsu_sel & fifo_empty & alu_nz;
        enq      = alu_nz & ~byp_sel;
        deq      = head_sel;
    end

    // Next value of the output register; addr/data hold when nothing is selected
    always_comb begin
        w_req_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (lsu_sel) begin
            w_req_d  = 1'b1;
            w_addr_d = lsu_wb_addr_i;
            w_data_d = lsu_wb_data_i;
        end else if (head_sel) begin
            // A squashed head just frees its slot without an MPRF write
            if (ent_vld_q[rd_ptr_q]) begin
                w_req_d  = 1'b1;
                w_addr_d = ent_addr_q[rd_ptr_q];
                w_data_d = ent_data_q[rd_ptr_q];
            end
        end else if (byp_sel) begin
            w_req_d  = 1'b1;
            w_addr_d = alu_wb_addr_i;
            w_data_d = alu_wb_data_i;
        end
    end

    // Entry valid bits: squash by the selected load, clear on dequeue, set on enqueue.
    // The entry enqueued this cycle is younger than the load, so it is never squashed.
    always_comb begin
        ent_vld_d = ent_vld_q;
        if (lsu_sel) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_addr_q[i] == lsu_wb_addr_i) begin
                    ent_vld_d[i] = 1'b0;
                end
            end
        end
        if (deq) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
        end
        if (enq) begin
            ent_vld_d[wr_ptr_q] = 1'b1;
        end
    end

    // Pointer and occupancy update; simultaneous enq/deq keeps the count
    always_comb begin
        wr_ptr_d = enq ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = deq ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq && !deq) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!enq && deq) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ent_vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ent_vld_q <= ent_vld_d;
            if (enq) begin
                ent_addr_q[wr_ptr_q] <= alu_wb_addr_i;
                ent_data_q[wr_ptr_q] <= alu_wb_data_i;
            end
        end
    end

    // MPRF write request register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_req_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            w_req_q  <= w_req_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    // Map FIFO ages onto physical slots for the forwarding search
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_idx[i]  = rd_ptr_q + PW'(i);
            slot_live[i] = (CW'(i) < cnt_q) & ent_vld_q[slot_idx[i]];
        end
    end

    // Forwarding: output register is the oldest candidate, then FIFO entries
    // oldest to youngest, so the last match wins and yields the newest value
    always_comb begin
        rs1_fwd_vd_o   = 1'b0;
        rs1_fwd_data_o = '0;
        rs2_fwd_vd_o   = 1'b0;
        rs2_fwd_data_o = '0;
        if (w_req_q && (w_addr_q == rs1_addr_i)) begin
            rs1_fwd_vd_o   = 1'b1;
            rs1_fwd_data_o = w_data_q;
        end
        if (w_req_q && (w_addr_q == rs2_addr_i)) begin
            rs2_fwd_vd_o   = 1'b1;
            rs2_fwd_data_o = w_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live[i] && (ent_addr_q[slot_idx[i]] == rs1_addr_i)) begin
                rs1_fwd_vd_o   = 1'b1;
                rs1_fwd_data_o = ent_data_q[slot_idx[i]];
            end
            if (slot_live[i] && (ent_addr_q[slot_idx[i]] == rs2_addr_i)) begin
                rs2_fwd_vd_o   = 1'b1;
                rs2_fwd_data_o = ent_data_q[slot_idx[i]];
            end
        end
        // x0 is hardwired; never forward it
        if (rs1_addr_i == '0) begin
            rs1_fwd_vd_o   = 1'b0;
            rs1_fwd_data_o = '0;
        end
        if (rs2_addr_i == '0) begin
            rs2_fwd_vd_o   = 1'b0;
            rs2_fwd_data_o = '0;
        end
    end

    // Registered outputs and idle status
    always_comb begin
        exu2mprf_w_req_o   = w_req_q;
        exu2mprf_rd_addr_o = w_addr_q;
        exu2mprf_rd_data_o = w_data_q;
        wb_idle_o          = fifo_empty & ~w_req_q;
    end

endmodule

// File: tb/tb_ycr1_pipe_mprf_wb.sv
// Bench for ycr1_pipe_mprf_wb: directed scenarios followed by random traffic
// with occasional mid-operation resets. A queue-based reference model predicts
// every MPRF write (with its cycle) into a scoreboard; a monitor pops and
// compares whenever the DUT raises its write request.
module tb_ycr1_pipe_mprf_wb;

    localparam int XLEN   = 32;
    localparam int AWIDTH = 5;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst_n;
    logic              alu_wb_req_i;
    logic [AWIDTH-1:0] alu_wb_addr_i;
    logic [XLEN-1:0]   alu_wb_data_i;
    logic              alu_wb_rdy_o;
    logic              lsu_wb_req_i;
    logic [AWIDTH-1:0] lsu_wb_addr_i;
    logic [XLEN-1:0]   lsu_wb_data_i;
    logic              exu2mprf_w_req_o;
    logic [AWIDTH-1:0] exu2mprf_rd_addr_o;
    logic [XLEN-1:0]   exu2mprf_rd_data_o;
    logic [AWIDTH-1:0] rs1_addr_i;
    logic [AWIDTH-1:0] rs2_addr_i;
    logic              rs1_fwd_vd_o;
    logic              rs2_fwd_vd_o;
    logic [XLEN-1:0]   rs1_fwd_data_o;
    logic [XLEN-1:0]   rs2_fwd_data_o;
    logic              wb_idle_o;

    ycr1_pipe_mprf_wb #(.XLEN(XLEN), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
        .rst_n              (rst_n),
        .clk                (clk),
        .alu_wb_req_i       (alu_wb_req_i),
        .alu_wb_addr_i      (alu_wb_addr_i),
        .alu_wb_data_i      (alu_wb_data_i),
        .alu_wb_rdy_o       (alu_wb_rdy_o),
        .lsu_wb_req_i       (lsu_wb_req_i),
        .lsu_wb_addr_i      (lsu_wb_addr_i),
        .lsu_wb_data_i      (lsu_wb_data_i),
        .exu2mprf_w_req_o   (exu2mprf_w_req_o),
        .exu2mprf_rd_addr_o (exu2mprf_rd_addr_o),
        .exu2mprf_rd_data_o (exu2mprf_rd_data_o),
        .rs1_addr_i         (rs1_addr_i),
        .rs2_addr_i         (rs2_addr_i),
        .rs1_fwd_vd_o       (rs1_fwd_vd_o),
        .rs2_fwd_vd_o       (rs2_fwd_vd_o),
        .rs1_fwd_data_o     (rs1_fwd_data_o),
        .rs2_fwd_data_o     (rs2_fwd_data_o),
        .wb_idle_o          (wb_idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: pending ALU results in program order plus the MPRF write stage
    typedef struct {
        logic [AWIDTH-1:0] a;
        logic [XLEN-1:0]   d;
        bit                v;
    } ent_t;

    typedef struct {
        int                c;
        logic [AWIDTH-1:0] a;
        logic [XLEN-1:0]   d;
    } wr_t;

    ent_t              mq[$];
    bit                m_ov = 1'b0;
    logic [AWIDTH-1:0] m_oa = '0;
    logic [XLEN-1:0]   m_od = '0;
    wr_t               exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Newest pending value for an operand address, x0 excluded
    function automatic logic [XLEN:0] mfwd(input logic [AWIDTH-1:0] rs);
        if (rs == '0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].v && mq[i].a == rs) return {1'b1, mq[i].d};
        end
        if (m_ov && m_oa == rs) return {1'b1, m_od};
        return '0;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs against the
    // model's current state, advance the model, then step past the edge.
    task automatic cycle(input bit ar, input logic [AWIDTH-1:0] aa, input logic [XLEN-1:0] ad,
                         input bit lr, input logic [AWIDTH-1:0] la, input logic [XLEN-1:0] ld,
                         input logic [AWIDTH-1:0] r1, input logic [AWIDTH-1:0] r2);
        logic [XLEN:0] f1, f2;
        bit rdy_e, lsu_sel, alu_nz, byp;
        ent_t e;
        wr_t w;
        alu_wb_req_i  = ar;
        alu_wb_addr_i = aa;
        alu_wb_data_i = ad;
        lsu_wb_req_i  = lr;
        lsu_wb_addr_i = la;
        lsu_wb_data_i = ld;
        rs1_addr_i    = r1;
        rs2_addr_i    = r2;
        #1;
        rdy_e = (mq.size() < DEPTH);
        chk("alu_rdy", alu_wb_rdy_o, rdy_e);
        chk("wb_idle", wb_idle_o, (mq.size() == 0) && !m_ov);
        chk("w_req", exu2mprf_w_req_o, m_ov);
        chk("w_addr_hold", exu2mprf_rd_addr_o, m_oa);
        chk("w_data_hold", exu2mprf_rd_data_o, m_od);
        f1 = mfwd(r1);
        f2 = mfwd(r2);
        chk("rs1_fwd_vd", rs1_fwd_vd_o, f1[XLEN]);
        chk("rs1_fwd_data", rs1_fwd_data_o, f1[XLEN-1:0]);
        chk("rs2_fwd_vd", rs2_fwd_vd_o, f2[XLEN]);
        chk("rs2_fwd_data", rs2_fwd_data_o, f2[XLEN-1:0]);

        lsu_sel = lr && (la != '0);
        alu_nz  = ar && rdy_e && (aa != '0);
        byp     = 1'b0;
        m_ov    = 1'b0;
        if (lsu_sel) begin
            foreach (mq[i]) if (mq[i].a == la) mq[i].v = 1'b0;
            m_ov = 1'b1; m_oa = la; m_od = ld;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.v) begin
                m_ov = 1'b1; m_oa = e.a; m_od = e.d;
            end
        end else if (alu_nz) begin
            byp  = 1'b1;
            m_ov = 1'b1; m_oa = aa; m_od = ad;
        end
        if (alu_nz && !byp) begin
            e.a = aa; e.d = ad; e.v = 1'b1;
            mq.push_back(e);
        end
        if (m_ov) begin
            w.c = cyc + 1; w.a = m_oa; w.d = m_od;
            exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [AWIDTH-1:0] r1, input logic [AWIDTH-1:0] r2);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, r1, r2);
    endtask

    // Asynchronous reset: outputs must clear immediately, before any clock edge
    task automatic do_reset();
        alu_wb_req_i = 1'b0; alu_wb_addr_i = '0; alu_wb_data_i = '0;
        lsu_wb_req_i = 1'b0; lsu_wb_addr_i = '0; lsu_wb_data_i = '0;
        rs1_addr_i   = 5'd3; rs2_addr_i    = 5'd4;
        rst_n = 1'b0;
        #1;
        chk("rst_w_req", exu2mprf_w_req_o, 0);
        chk("rst_w_addr", exu2mprf_rd_addr_o, 0);
        chk("rst_w_data", exu2mprf_rd_data_o, 0);
        chk("rst_idle", wb_idle_o, 1);
        chk("rst_rdy", alu_wb_rdy_o, 1);
        chk("rst_rs1_vd", rs1_fwd_vd_o, 0);
        chk("rst_rs1_data", rs1_fwd_data_o, 0);
        chk("rst_rs2_vd", rs2_fwd_vd_o, 0);
        chk("rst_rs2_data", rs2_fwd_data_o, 0);
        mq.delete();
        exp_q.delete();
        m_ov = 1'b0; m_oa = '0; m_od = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every presented write must be the next predicted one, on time
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write: got none expected rd %0d data %h (cycle %0d)",
                         exp_q[0].a, exp_q[0].d, exp_q[0].c);
                void'(exp_q.pop_front());
            end
            if (exu2mprf_w_req_o) begin
                if (exp_q.size() == 0 || exp_q[0].c != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got rd %0d data %h expected no write (cycle %0d)",
                             exu2mprf_rd_addr_o, exu2mprf_rd_data_o, cyc);
                end else begin
                    chk("mprf_addr", exu2mprf_rd_addr_o, exp_q[0].a);
                    chk("mprf_data", exu2mprf_rd_data_o, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();

        // Simple ALU write through the bypass, forwarded on rs1 while in flight
        cycle(1, 5'd5, 32'h1234_5678, 0, '0, '0, '0, '0);
        idle(1, 5'd5, 5'd0);
        idle(2, 5'd5, 5'd5);

        // Collision: load wins, ALU result follows one cycle later
        cycle(1, 5'd7, 32'h77, 1, 5'd3, 32'hAAAA_0000, 5'd7, 5'd3);
        idle(3, 5'd7, 5'd3);

        // Backpressure: sustained loads fill the FIFO and drop ready
        for (int i = 0; i < 6; i++)
            cycle(1, 5'(10 + i), 32'(32'h100 + i), 1, 5'(20 + i), 32'(32'h200 + i), 5'd10, 5'd11);
        idle(4, 5'd10, 5'd11);

        // Squash: buffered rd9 is overtaken by a load to rd9
        cycle(1, 5'd9, 32'h11, 1, 5'd2, 32'h2, 5'd0, 5'd9);
        cycle(0, '0, '0, 1, 5'd9, 32'h22, 5'd0, 5'd9);
        idle(3, 5'd0, 5'd9);

        // rd = 0 on both producers
        cycle(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
        idle(2, 5'd0, 5'd0);

        // Reset mid-drain with two buffered entries and a pending write
        cycle(1, 5'd2, 32'h2222, 1, 5'd1, 32'h1111, 5'd2, 5'd1);
        cycle(1, 5'd4, 32'h4444, 1, 5'd3, 32'h3333, 5'd2, 5'd4);
        do_reset();
        idle(4, 5'd2, 5'd4);

        // Random traffic on a narrow address range to force collisions and squashes
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        idle(8, 5'd1, 5'd2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
